// File: rtl/neopixel_pkg.sv
// Shared definitions for the NeoPixel (WS2812) strip controller and its producer.
// Holds the controller state encoding, the colour channel enum, default bit
// timing at 50 MHz and the brightness cap level used by NEO_BRIGHTNESS_CAP_EN.
package neopixel_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SEND_HIGH = 2'd1,
        SEND_LOW  = 2'd2,
        LATCH     = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        GREEN = 2'd0,
        RED   = 2'd1,
        BLUE  = 2'd2
    } color_t;

    localparam int DEF_NUM_PIXELS = 5;
    localparam int DEF_T0H        = 18;
    localparam int DEF_T0L        = 40;
    localparam int DEF_T1H        = 35;
    localparam int DEF_T1L        = 30;
    localparam int DEF_T_RESET    = 2500;

    localparam logic [7:0] BRIGHT_CAP = 8'h40;

endpackage

// File: rtl/neo_bit_timer.sv
// Loadable down-counter that times one phase of the WS2812 waveform.
// Loading N makes expired rise in the N-th cycle after the load edge, so the
// owner can switch phase (and reload) on that same edge.
module neo_bit_timer #(
    parameter int CNT_W = 12
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             expired
);

    logic [CNT_W-1:0] count;

    // Reload on request, otherwise count down and park at zero.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign expired = (count == CNT_W'(1));

endmodule

// File: rtl/neopixel_controller.sv
// WS2812 frame buffer and serialiser for a short NeoPixel strip.
// Accepts per-channel colour writes while idle, then shifts the whole GRB
// buffer out on neo_data with exact high/low cycle counts and a latch gap.
// Build option: NEO_BRIGHTNESS_CAP_EN clamps stored levels to 8'h40.
module neopixel_controller
    import neopixel_pkg::*;
#(
    parameter int NUM_PIXELS = DEF_NUM_PIXELS,
    parameter int T0H        = DEF_T0H,
    parameter int T0L        = DEF_T0L,
    parameter int T1H        = DEF_T1H,
    parameter int T1L        = DEF_T1L,
    parameter int T_RESET    = DEF_T_RESET
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [2:0] pixel_index,
    input  logic [1:0] color_index,
    input  logic [7:0] color_level,
    input  logic       load_color,
    input  logic       send_it,
    output logic       neo_data,
    output logic       ready_to_load,
    output logic       ready_to_send,
    output logic       done_send,
    output logic       done_wait
);

    localparam int         CNT_W    = $clog2(T_RESET + 1);
    localparam logic [2:0] LAST_PIX = 3'(NUM_PIXELS - 1);

    state_t           state;
    logic [7:0]       frame_mem [NUM_PIXELS][3];
    logic [23:0]      pix_word  [NUM_PIXELS];
    logic [2:0]       pix;
    logic [4:0]       bit_idx;
    logic [2:0]       nxt_pix;
    logic [4:0]       nxt_idx;
    logic             cur_bit;
    logic             nxt_bit;
    logic             first_bit;
    logic             last_bit;
    logic             write_en;
    logic [7:0]       wr_level;
    logic             tmr_load;
    logic [CNT_W-1:0] tmr_val;
    logic             tmr_exp;

    function automatic logic [7:0] cap_level(input logic [7:0] lvl);
`ifdef NEO_BRIGHTNESS_CAP_EN
        cap_level = (lvl > BRIGHT_CAP) ? BRIGHT_CAP : lvl;
`else
        cap_level = lvl;
`endif
    endfunction

    function automatic logic [CNT_W-1:0] high_len(input logic b);
        high_len = b ? CNT_W'(T1H) : CNT_W'(T0H);
    endfunction

    function automatic logic [CNT_W-1:0] low_len(input logic b);
        low_len = b ? CNT_W'(T1L) : CNT_W'(T0L);
    endfunction

    assign write_en = (state == IDLE) && load_color &&
                      (pixel_index <= LAST_PIX) && (color_index != 2'd3);
    assign wr_level = cap_level(color_level);

    // Each pixel viewed as one 24-bit word, G in the MSBs so bit 23 goes first.
    always_comb begin
        for (int p = 0; p < NUM_PIXELS; p++) begin
            pix_word[p] = {frame_mem[p][0], frame_mem[p][1], frame_mem[p][2]};
        end
    end

    // Pixel index saturates on the last pixel; the frame ends there instead.
    assign last_bit = (pix == LAST_PIX) && (bit_idx == 5'd0);
    assign nxt_pix  = ((bit_idx == 5'd0) && (pix != LAST_PIX)) ? pix + 3'd1 : pix;
    assign nxt_idx  = (bit_idx == 5'd0) ? 5'd23 : bit_idx - 5'd1;
    assign cur_bit  = pix_word[pix][bit_idx];
    assign nxt_bit  = pix_word[nxt_pix][nxt_idx];

    // A load in the send cycle lands in the buffer on the same edge, so the
    // very first bit must see the incoming green MSB of pixel 0.
    assign first_bit = (write_en && (pixel_index == 3'd0) && (color_index == GREEN))
                       ? wr_level[7] : frame_mem[0][0][7];

    // Pick the duration of the phase being entered on this edge.
    always_comb begin
        tmr_load = 1'b0;
        tmr_val  = '0;
        case (state)
            IDLE: begin
                if (send_it) begin
                    tmr_load = 1'b1;
                    tmr_val  = high_len(first_bit);
                end
            end
            SEND_HIGH: begin
                if (tmr_exp) begin
                    tmr_load = 1'b1;
                    tmr_val  = low_len(cur_bit);
                end
            end
            SEND_LOW: begin
                if (tmr_exp) begin
                    tmr_load = 1'b1;
                    tmr_val  = last_bit ? CNT_W'(T_RESET) : high_len(nxt_bit);
                end
            end
            default: begin
                tmr_load = 1'b0;
            end
        endcase
    end

    neo_bit_timer #(
        .CNT_W(CNT_W)
    ) u_timer (
        .clock    (clock),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (tmr_val),
        .expired  (tmr_exp)
    );

    // Frame buffer: written only while idle, cleared by reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int p = 0; p < NUM_PIXELS; p++) begin
                for (int c = 0; c < 3; c++) begin
                    frame_mem[p][c] <= 8'h00;
                end
            end
        end else if (write_en) begin
            frame_mem[pixel_index][color_index] <= wr_level;
        end
    end

    // Waveform sequencer: phase transitions, bit/pixel position, line and pulses.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            pix       <= 3'd0;
            bit_idx   <= 5'd23;
            neo_data  <= 1'b0;
            done_send <= 1'b0;
            done_wait <= 1'b0;
        end else begin
            done_send <= 1'b0;
            done_wait <= 1'b0;
            case (state)
                IDLE: begin
                    if (send_it) begin
                        state    <= SEND_HIGH;
                        pix      <= 3'd0;
                        bit_idx  <= 5'd23;
                        neo_data <= 1'b1;
                    end
                end
                SEND_HIGH: begin
                    if (tmr_exp) begin
                        state    <= SEND_LOW;
                        neo_data <= 1'b0;
                    end
                end
                SEND_LOW: begin
                    if (tmr_exp) begin
                        if (last_bit) begin
                            state     <= LATCH;
                            done_send <= 1'b1;
                        end else begin
                            state    <= SEND_HIGH;
                            pix      <= nxt_pix;
                            bit_idx  <= nxt_idx;
                            neo_data <= 1'b1;
                        end
                    end
                end
                default: begin
                    neo_data <= 1'b0;
                    if (tmr_exp) begin
                        state     <= IDLE;
                        done_wait <= 1'b1;
                    end
                end
            endcase
        end
    end

    assign ready_to_load = (state == IDLE);
    assign ready_to_send = (state == IDLE);

endmodule

// File: tb/tb_neopixel_controller.sv
// Self-checking bench for neopixel_controller: a behavioural model of the GRB
// buffer predicts every bit's high/low lengths, frame length and latch gap.
module tb_neopixel_controller;

    localparam int NP  = 5;
    localparam int NB  = 24 * NP;
    localparam int BT0H = 18;
    localparam int BT0L = 40;
    localparam int BT1H = 35;
    localparam int BT1L = 30;
    localparam int BTR  = 2500;
`ifdef NEO_BRIGHTNESS_CAP_EN
    localparam logic [7:0] EXP_FF = 8'h40;
`else
    localparam logic [7:0] EXP_FF = 8'hFF;
`endif

    logic       clock;
    logic       reset;
    logic [2:0] pixel_index;
    logic [1:0] color_index;
    logic [7:0] color_level;
    logic       load_color;
    logic       send_it;
    logic       neo_data;
    logic       ready_to_load;
    logic       ready_to_send;
    logic       done_send;
    logic       done_wait;

    int total = 0;
    int bad   = 0;

    logic [7:0] m_buf [NP][3];
    bit         cap_bits [NB];

    neopixel_controller dut (
        .clock         (clock),
        .reset         (reset),
        .pixel_index   (pixel_index),
        .color_index   (color_index),
        .color_level   (color_level),
        .load_color    (load_color),
        .send_it       (send_it),
        .neo_data      (neo_data),
        .ready_to_load (ready_to_load),
        .ready_to_send (ready_to_send),
        .done_send     (done_send),
        .done_wait     (done_wait)
    );

    initial clock = 1'b0;
    always #10 clock = ~clock;

    function automatic logic [7:0] capv(input logic [7:0] lvl);
`ifdef NEO_BRIGHTNESS_CAP_EN
        return (lvl > 8'h40) ? 8'h40 : lvl;
`else
        return lvl;
`endif
    endfunction

    function automatic bit model_bit(input int i);
        logic [23:0] w;
        int p;
        int b;
        p = i / 24;
        b = 23 - (i % 24);
        w = {m_buf[p][0], m_buf[p][1], m_buf[p][2]};
        return w[b];
    endfunction

    function automatic int model_len();
        int s;
        s = 0;
        for (int i = 0; i < NB; i++) s += model_bit(i) ? (BT1H + BT1L) : (BT0H + BT0L);
        return s;
    endfunction

    task automatic model_clear();
        for (int p = 0; p < NP; p++)
            for (int c = 0; c < 3; c++) m_buf[p][c] = 8'h00;
    endtask

    task automatic model_write(input logic [2:0] p, input logic [1:0] c, input logic [7:0] l);
        if (p < NP && c != 2'd3) m_buf[p][c] = capv(l);
    endtask

    task automatic do_load(input logic [2:0] p, input logic [1:0] c, input logic [7:0] l);
        @(negedge clock);
        pixel_index = p;
        color_index = c;
        color_level = l;
        load_color  = 1'b1;
        send_it     = 1'b0;
        model_write(p, c, l);
    endtask

    task automatic start_frame(input bit with_load, input logic [2:0] p,
                               input logic [1:0] c, input logic [7:0] l);
        @(negedge clock);
        send_it    = 1'b1;
        load_color = with_load;
        pixel_index = p;
        color_index = c;
        color_level = l;
        if (with_load) model_write(p, c, l);
    endtask

    // Measures every bit after a start_frame, then done_send/done_wait spacing.
    task automatic capture_frame(input bit inject, output int flen);
        int hi, lo, t, waited, eh, el, exp_len;
        bit b;
        exp_len = model_len();
        @(negedge clock);
        send_it    = 1'b0;
        load_color = 1'b0;
        t = 1;
        total++;
        if (ready_to_send !== 1'b0) begin
            bad++;
            $display("FAIL busy_ready: ready_to_send=%b required 0", ready_to_send);
        end
        for (int i = 0; i < NB; i++) begin
            b  = model_bit(i);
            eh = b ? BT1H : BT0H;
            el = b ? BT1L : BT0L;
            hi = 0;
            while (neo_data === 1'b1 && hi < 200) begin
                hi++;
                if (inject && i == 2 && hi == 1) begin
                    load_color  = 1'b1;
                    send_it     = 1'b1;
                    pixel_index = 3'($urandom_range(0, 4));
                    color_index = 2'($urandom_range(0, 2));
                    color_level = 8'($urandom_range(0, 255));
                end
                @(negedge clock);
                t++;
            end
            load_color = 1'b0;
            send_it    = 1'b0;
            lo = 0;
            while (neo_data === 1'b0 && done_send !== 1'b1 && lo < 200) begin
                lo++;
                @(negedge clock);
                t++;
            end
            cap_bits[i] = (hi > 26);
            total++;
            if (hi != eh || lo != el) begin
                bad++;
                $display("FAIL bit%0d_timing: high=%0d low=%0d required high=%0d low=%0d",
                         i, hi, lo, eh, el);
            end
        end
        flen = t - 1;
        total++;
        if (done_send !== 1'b1 || flen != exp_len) begin
            bad++;
            $display("FAIL frame_len: done_send=%b cycles=%0d required 1 and %0d",
                     done_send, flen, exp_len);
        end
        @(negedge clock);
        waited = 1;
        total++;
        if (done_send !== 1'b0) begin
            bad++;
            $display("FAIL done_send_pulse: done_send=%b required 0", done_send);
        end
        while (done_wait !== 1'b1 && waited < 3000) begin
            @(negedge clock);
            waited++;
        end
        total++;
        if (waited != BTR || neo_data !== 1'b0 || ready_to_load !== 1'b1 || ready_to_send !== 1'b1) begin
            bad++;
            $display("FAIL latch_gap: cycles=%0d neo=%b rl=%b rs=%b required %0d 0 1 1",
                     waited, neo_data, ready_to_load, ready_to_send, BTR);
        end
        @(negedge clock);
        total++;
        if (done_wait !== 1'b0) begin
            bad++;
            $display("FAIL done_wait_pulse: done_wait=%b required 0", done_wait);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        model_clear();
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            total++;
            if ({neo_data, ready_to_load, ready_to_send, done_send, done_wait} !== 5'b01100) begin
                bad++;
                $display("FAIL idle_cycle%0d: {neo,rl,rs,ds,dw}=%b required 01100", i,
                         {neo_data, ready_to_load, ready_to_send, done_send, done_wait});
            end
        end
    endtask

    task automatic test_all_zero();
        int flen;
        start_frame(1'b0, 3'd0, 2'd0, 8'h00);
        capture_frame(1'b0, flen);
        total++;
        if (flen != 6960) begin
            bad++;
            $display("FAIL zero_frame_len: cycles=%0d required 6960", flen);
        end
    endtask

    task automatic test_single_green();
        int flen;
        do_load(3'd0, 2'd0, 8'h80);
        start_frame(1'b0, 3'd0, 2'd0, 8'h00);
        capture_frame(1'b0, flen);
    endtask

    task automatic test_random_frame();
        int flen;
        for (int p = 0; p < NP; p++)
            for (int c = 0; c < 3; c++)
                do_load(3'(p), 2'(c), 8'($urandom_range(0, 255)));
        start_frame(1'b1, 3'd0, 2'd0, 8'($urandom_range(0, 255)));
        capture_frame(1'b0, flen);
    endtask

    task automatic test_dropped_loads();
        int flen;
        do_load(3'd5, 2'd0, 8'($urandom_range(0, 255)));
        do_load(3'd6, 2'd1, 8'($urandom_range(0, 255)));
        do_load(3'd7, 2'd2, 8'($urandom_range(0, 255)));
        do_load(3'd2, 2'd3, 8'($urandom_range(0, 255)));
        do_load(3'd0, 2'd3, 8'($urandom_range(0, 255)));
        start_frame(1'b0, 3'd0, 2'd0, 8'h00);
        capture_frame(1'b1, flen);
    endtask

    task automatic test_same_cycle();
        int flen;
        logic [7:0] last_byte;
        logic [7:0] red1_byte;
        do_load(3'd1, 2'd1, 8'hFF);
        start_frame(1'b1, 3'd4, 2'd2, 8'hFF);
        capture_frame(1'b0, flen);
        for (int k = 0; k < 8; k++) begin
            last_byte[7-k] = cap_bits[NB-8+k];
            red1_byte[7-k] = cap_bits[24+8+k];
        end
        total++;
        if (last_byte !== EXP_FF) begin
            bad++;
            $display("FAIL last_byte: got %h required %h", last_byte, EXP_FF);
        end
        total++;
        if (red1_byte !== EXP_FF) begin
            bad++;
            $display("FAIL pix1_red_byte: got %h required %h", red1_byte, EXP_FF);
        end
    endtask

    task automatic test_reset_midframe();
        int rises, flen;
        logic prev;
        start_frame(1'b0, 3'd0, 2'd0, 8'h00);
        rises = 0;
        prev  = 1'b0;
        for (int n = 0; n < 10000 && rises < 41; n++) begin
            @(negedge clock);
            send_it    = 1'b0;
            load_color = 1'b0;
            if (neo_data === 1'b1 && prev === 1'b0) rises++;
            prev = neo_data;
        end
        total++;
        if (rises != 41) begin
            bad++;
            $display("FAIL reach_bit40: rises=%0d required 41", rises);
        end
        #3 reset = 1'b1;
        #1;
        total++;
        if ({neo_data, ready_to_load, ready_to_send, done_send, done_wait} !== 5'b01100) begin
            bad++;
            $display("FAIL async_reset: {neo,rl,rs,ds,dw}=%b required 01100",
                     {neo_data, ready_to_load, ready_to_send, done_send, done_wait});
        end
        repeat (2) @(negedge clock);
        reset = 1'b0;
        model_clear();
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            total++;
            if ({neo_data, done_send, done_wait} !== 3'b000) begin
                bad++;
                $display("FAIL post_reset%0d: {neo,ds,dw}=%b required 000", i,
                         {neo_data, done_send, done_wait});
            end
        end
        start_frame(1'b0, 3'd0, 2'd0, 8'h00);
        capture_frame(1'b0, flen);
        total++;
        if (flen != 6960) begin
            bad++;
            $display("FAIL cleared_frame_len: cycles=%0d required 6960", flen);
        end
    endtask

    initial begin
        reset       = 1'b1;
        pixel_index = 3'd0;
        color_index = 2'd0;
        color_level = 8'h00;
        load_color  = 1'b0;
        send_it     = 1'b0;
        model_clear();
        test_reset();
        test_all_zero();
        test_single_green();
        test_random_frame();
        test_dropped_loads();
        test_same_cycle();
        test_reset_midframe();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/neopixel_controller.md
# neopixel_controller

Consumer end of the NeoPixel load/send handshake. It accepts per-pixel colour writes into an internal GRB frame buffer for a 5-LED strip. On request it serialises the whole buffer onto the single-wire WS2812 data line with cycle-exact high/low timing, then holds the line low for the latch period. It sits between the producer FSM and the `neo_data` pin and generates every `ready_*`/`done_*` handshake that producer consumes.

## Interface
Parameters:
- NUM_PIXELS, 5, LEDs on the strip
- T0H, 18, high cycles for a 0 bit (50 MHz clock)
- T0L, 40, low cycles for a 0 bit
- T1H, 35, high cycles for a 1 bit
- T1L, 30, low cycles for a 1 bit
- T_RESET, 2500, latch low period in cycles (50 us)

Ports:
- clock  in  1  system clock; one clock domain
- reset  in  1  asynchronous, active-high
- pixel_index  in  3  target pixel of a load
- color_index  in  2  0=green, 1=red, 2=blue, 3=ignored
- color_level  in  8  intensity to store
- load_color  in  1  write strobe
- send_it  in  1  start-frame strobe
- neo_data  out  1  serial LED data
- ready_to_load  out  1  loads accepted this cycle
- ready_to_send  out  1  send accepted this cycle
- done_send  out  1  one-cycle pulse: last bit finished
- done_wait  out  1  one-cycle pulse: latch period finished

## Operation
- States: IDLE, SEND_HIGH, SEND_LOW, LATCH.
- Reset values: state IDLE, buffer all 0, neo_data 0, done_send 0, done_wait 0. ready_to_load and ready_to_send are 1, because they decode IDLE.
- IDLE, load:
  - A write occurs when `load_color` is 1, pixel_index < NUM_PIXELS, and color_index != 3.
  - The write stores color_level into buffer[pixel_index][color_index].
  - Any other load is silently dropped.
  - Back-to-back loads are legal, one per cycle.
- IDLE, send_it:
  - Moves to SEND_HIGH with pixel 0, bit 23.
  - A load in the same cycle commits first and is included in the frame.
- Bit order:
  - Pixels go from 0 to NUM_PIXELS-1.
  - Within each pixel, bits go G[7]..G[0], then R[7]..R[0], then B[7]..B[0].
  - The frame is 24×NUM_PIXELS bits.
- SEND_HIGH:
  - neo_data=1 for T1H or T0H cycles, selected by the current bit.
  - Then moves to SEND_LOW.
- SEND_LOW:
  - neo_data=0 for T1L or T0L cycles.
  - Then advances to the next bit and returns to SEND_HIGH.
  - After the last bit of the last pixel it moves to LATCH and pulses done_send.
- LATCH:
  - neo_data=0 for T_RESET cycles.
  - Then pulses done_wait and returns to IDLE.
- Outside IDLE:
  - load_color and send_it are ignored.
  - The buffer is frozen during a frame.
- Reset mid-frame: immediate return to IDLE, neo_data 0, buffer cleared, no done pulses.

## Timing
- neo_data is registered. send_it sampled at edge k gives neo_data=1 from cycle k+1.
- Bit period: 0 bit = T0H+T0L = 58 cycles; 1 bit = T1H+T1L = 65 cycles.
- done_send is high during the first LATCH cycle.
- done_wait is high during the cycle IDLE is re-entered.
- ready_to_load and ready_to_send rise in that same cycle.
- Frame length = Σ bit periods. An all-zero 5-pixel frame is 120×58 = 6960 cycles.
- Timing counter width: $clog2(T_RESET+1) bits. It counts down to 1 and the phase changes on the next edge.
- The bit index counts 23 down to 0 and wraps to 23 with a pixel increment. The pixel index saturates at the last pixel and the frame ends.

## Configuration
- NEO_BRIGHTNESS_CAP_EN defined: the stored level is min(color_level, 8'h40). This protects the strip supply.
- NEO_BRIGHTNESS_CAP_EN undefined: color_level is stored unmodified.
- No timing or handshake difference between the two builds.

## Structure
- Shared package `neopixel_pkg`:
  - state enum
  - `color_t` enum (GREEN=0, RED=1, BLUE=2)
  - default timing localparams and the 8'h40 cap constant; the producer imports the same color_t.
- Sub-module `neo_bit_timer`:
  - Loadable down-counter that takes a cycle count and raises `expired`.
  - The FSM reloads it with T*H, T*L, or T_RESET per phase.

## Test plan
- Reset, then idle: neo_data=0, ready_to_load=ready_to_send=1, done_* = 0 for 100 cycles.
- Load pixel 0 green=8'h80, then send_it:
  - First bit is high 35 / low 30.
  - The next 119 bits are each high 18 / low 40.
  - done_send at frame end, done_wait exactly 2500 cycles later.
- All-zero frame: done_send 6960 cycles after send_it is sampled.
- Loads at pixel_index=5, at color_index=3, and any load during SEND_HIGH: the next frame's bits are unchanged.
- load_color (pixel 4, blue=8'hFF) and send_it in the same cycle: the last 8 bits of the frame are all 1s.
- Reset asserted mid-frame at bit 40: neo_data is 0 immediately, and the next frame shows a cleared buffer.
- Build with NEO_BRIGHTNESS_CAP_EN, load 8'hFF: serialised byte = 8'h40.
